data_ram_ctrl: RTL and testbench



---
 rtl/data_ram_ctrl_pkg.sv | 23 ++
 rtl/data_ram_ctrl_if.sv | 12 +
 rtl/data_ram_ctrl_timer.sv | 51 +++++
 rtl/data_ram_ctrl.sv | 48 ++++
 tb/tb_data_ram_ctrl.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/data_ram_ctrl_pkg.sv
// data_ram_ctrl_pkg: bus types, region codes, timer register map and lane-merge helper
package data_ram_ctrl_pkg;
  typedef logic [31:0] data_addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  sel_t;
  localparam logic [3:0] DramRegionRam   = 4'h0;
  localparam logic [3:0] DramRegionTimer = 4'h1;
  typedef enum logic [1:0] {
    TimerCount   = 2'd0,
    TimerCompare = 2'd1,
    TimerCtrl    = 2'd2,
    TimerRsvd    = 2'd3
  } timer_off_e;
  localparam int CtrlEnBit   = 0;
  localparam int CtrlIeBit   = 1;
  localparam int CtrlPendBit = 2;
  localparam data_t TimerCompareReset = 32'hFFFF_FFFF;
  function automatic data_t lane_merge(data_t old_w, data_t new_w, sel_t sel);
    data_t r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sel[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/data_ram_ctrl_if.sv
// data_ram_ctrl_if: core data-memory port bundle (core = master, RAM controller = slave)
interface data_ram_ctrl_if;
  import data_ram_ctrl_pkg::*;
  logic       ce;
  logic       we;
  data_addr_t addr;
  sel_t       sel;
  data_t      data_i;
  data_t      data_o;
  modport master (output ce, we, addr, sel, data_i, input data_o);
  modport slave  (input ce, we, addr, sel, data_i, output data_o);
endinterface

// File: rtl/data_ram_ctrl_timer.sv
// data_ram_ctrl_timer: COUNT/COMPARE/CTRL timer with compare-match pending flag and registered interrupt
module data_ram_ctrl_timer
  import data_ram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  timer_off_e off,
  input  sel_t       sel,
  input  data_t      wdata,
  output data_t      rdata,
  output logic       int_o
);
  data_t count_q, count_d, compare_q, compare_d;
  logic  en_q, en_d, ie_q, ie_d, pend_q, pend_d, irq_q, irq_d;
  logic  wr_cnt, wr_cmp, wr_ctl, match;
  always_comb begin
    wr_cnt    = wr && off == TimerCount;
    wr_cmp    = wr && off == TimerCompare;
    wr_ctl    = wr && off == TimerCtrl && sel[0];
    match     = en_q && count_q == compare_q;
    count_d   = wr_cnt ? lane_merge(count_q, wdata, sel) : count_q + {31'd0, en_q};
    compare_d = wr_cmp ? lane_merge(compare_q, wdata, sel) : compare_q;
    en_d      = wr_ctl ? wdata[CtrlEnBit] : en_q;
    ie_d      = wr_ctl ? wdata[CtrlIeBit] : ie_q;
    // a match in the same cycle as the W1C keeps PEND set
    pend_d    = match | (pend_q & ~(wr_ctl & wdata[CtrlPendBit]));
    irq_d     = pend_q & ie_q;
    rdata     = off == TimerCount   ? count_q :
                off == TimerCompare ? compare_q :
                off == TimerCtrl    ? {29'd0, pend_q, ie_q, en_q} : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      compare_q <= TimerCompareReset;
      en_q      <= 1'b0;
      ie_q      <= 1'b0;
      pend_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      en_q      <= en_d;
      ie_q      <= ie_d;
      pend_q    <= pend_d;
      irq_q     <= irq_d;
    end
  end
  assign int_o = irq_q;
endmodule

// File: rtl/data_ram_ctrl.sv
// data_ram_ctrl: core data-memory responder with byte-lane RAM; timer at region 0x1 when DATA_RAM_TIMER_EN is defined
module data_ram_ctrl
  import data_ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic            clk,
  input  logic            rst,
  data_ram_ctrl_if.slave  bus,
  output logic            timer_int_o
);
  logic [3:0]        region;
  logic [ADDR_W-1:0] idx;
  logic              ram_hit, tmr_hit, unused_addr;
  data_t             ram_rd, tmr_rd;
  data_t             mem [2**ADDR_W];
  assign region      = bus.addr[31:28];
  assign idx         = bus.addr[ADDR_W+1:2];
  assign ram_hit     = bus.ce && region == DramRegionRam;
  assign ram_rd      = mem[idx];
  assign unused_addr = ^{bus.addr[27:ADDR_W+2], bus.addr[1:0]};
  // RAM is not cleared by rst, but a store coinciding with rst is dropped
  always_ff @(posedge clk) begin
    if (!rst && ram_hit && bus.we)
      for (int i = 0; i < 4; i++)
        if (bus.sel[i]) mem[idx][8*i +: 8] <= bus.data_i[8*i +: 8];
  end
`ifdef DATA_RAM_TIMER_EN
  assign tmr_hit = bus.ce && region == DramRegionTimer;
  data_ram_ctrl_timer u_timer (
    .clk   (clk),
    .rst   (rst),
    .wr    (tmr_hit && bus.we),
    .off   (timer_off_e'(bus.addr[3:2])),
    .sel   (bus.sel),
    .wdata (bus.data_i),
    .rdata (tmr_rd),
    .int_o (timer_int_o)
  );
`else
  assign tmr_hit     = 1'b0;
  assign tmr_rd      = '0;
  assign timer_int_o = 1'b0;
`endif
  assign bus.data_o = (rst || bus.we) ? '0 :
                      ram_hit         ? ram_rd :
                      tmr_hit         ? tmr_rd : '0;
endmodule

// File: tb/tb_data_ram_ctrl.sv
// tb_data_ram_ctrl: directed self-checking bench for data_ram_ctrl (timer checks when DATA_RAM_TIMER_EN is defined)
module tb_data_ram_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic timer_int_o;
  int   errors = 0;
  int   checks = 0;
  data_ram_ctrl_if bus ();
  data_ram_ctrl #(.ADDR_W(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .timer_int_o (timer_int_o)
  );
  always #5 clk = ~clk;
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output logic [31:0] q);
    bus.ce = 1'b1; bus.we = 1'b1; bus.addr = a; bus.data_i = d; bus.sel = s;
    #1 q = bus.data_o;
    @(negedge clk);
    bus.ce = 1'b0; bus.we = 1'b0;
  endtask
  task automatic load(input logic [31:0] a, input logic [3:0] s, output logic [31:0] q);
    bus.ce = 1'b1; bus.we = 1'b0; bus.addr = a; bus.sel = s;
    #1 q = bus.data_o;
    @(negedge clk);
    bus.ce = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1; bus.ce = 1'b1; bus.we = 1'b0; bus.addr = 32'h10; bus.sel = 4'hF; bus.data_i = '0;
    @(negedge clk);
    #1;
    checks++; if (bus.data_o !== 32'h0) begin errors++; $display("FAIL reset_data_o got=%h exp=0", bus.data_o); end
    checks++; if (timer_int_o !== 1'b0) begin errors++; $display("FAIL reset_int got=%b exp=0", timer_int_o); end
    @(negedge clk);
    rst = 1'b0; bus.ce = 1'b0;
  endtask
  task automatic test_ram_lanes;
    logic [31:0] q;
    store(32'h10, 32'hDEADBEEF, 4'hF, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL store_data_o got=%h exp=0", q); end
    load(32'h10, 4'hF, q);
    checks++; if (q !== 32'hDEADBEEF) begin errors++; $display("FAIL full_word got=%h exp=deadbeef", q); end
    store(32'h10, 32'h00000055, 4'b0001, q);
    load(32'h10, 4'hF, q);
    checks++; if (q !== 32'hDEADBE55) begin errors++; $display("FAIL lane0 got=%h exp=deadbe55", q); end
    store(32'h10, 32'h12000000, 4'b1000, q);
    load(32'h10, 4'b0000, q);
    checks++; if (q !== 32'h12ADBE55) begin errors++; $display("FAIL lane3_sel0_load got=%h exp=12adbe55", q); end
  endtask
  task automatic test_alias_unmapped;
    logic [31:0] q;
    store(32'h0000_1010, 32'hA5A5A5A5, 4'hF, q);
    load(32'h10, 4'hF, q);
    checks++; if (q !== 32'hA5A5A5A5) begin errors++; $display("FAIL alias got=%h exp=a5a5a5a5", q); end
    load(32'h2000_0000, 4'hF, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL unmapped_load got=%h exp=0", q); end
    store(32'h3000_0010, 32'h0, 4'hF, q);
    load(32'h10, 4'hF, q);
    checks++; if (q !== 32'hA5A5A5A5) begin errors++; $display("FAIL unmapped_store got=%h exp=a5a5a5a5", q); end
    bus.ce = 1'b0; bus.we = 1'b0; bus.addr = 32'h10;
    #1;
    checks++; if (bus.data_o !== 32'h0) begin errors++; $display("FAIL ce_low got=%h exp=0", bus.data_o); end
    @(negedge clk);
  endtask
`ifdef DATA_RAM_TIMER_EN
  task automatic test_timer;
    logic [31:0] q;
    store(32'h1000_0004, 32'd5, 4'hF, q);
    store(32'h1000_0000, 32'd0, 4'hF, q);
    store(32'h1000_0008, 32'h3, 4'hF, q);
    load(32'h1000_0000, 4'hF, q);
    checks++; if (q !== 32'd0) begin errors++; $display("FAIL count_start got=%h exp=0", q); end
    repeat (4) @(negedge clk);
    load(32'h1000_0000, 4'hF, q);
    checks++; if (q !== 32'd5) begin errors++; $display("FAIL count_five got=%h exp=5", q); end
    checks++; if (timer_int_o !== 1'b0) begin errors++; $display("FAIL int_lag got=%b exp=0", timer_int_o); end
    load(32'h1000_0008, 4'hF, q);
    checks++; if (q !== 32'h7) begin errors++; $display("FAIL pend_set got=%h exp=7", q); end
    checks++; if (timer_int_o !== 1'b1) begin errors++; $display("FAIL int_set got=%b exp=1", timer_int_o); end
    store(32'h1000_0008, 32'h7, 4'b0001, q);
    load(32'h1000_0008, 4'hF, q);
    checks++; if (q !== 32'h3) begin errors++; $display("FAIL pend_w1c got=%h exp=3", q); end
    checks++; if (timer_int_o !== 1'b0) begin errors++; $display("FAIL int_clear got=%b exp=0", timer_int_o); end
    store(32'h1000_0000, 32'd100, 4'hF, q);
    load(32'h1000_0000, 4'hF, q);
    checks++; if (q !== 32'd100) begin errors++; $display("FAIL count_store_wins got=%h exp=64", q); end
    store(32'h1000_0000, 32'hFFFF_FFFF, 4'hF, q);
    load(32'h1000_0000, 4'hF, q);
    checks++; if (q !== 32'hFFFF_FFFF) begin errors++; $display("FAIL count_max got=%h exp=ffffffff", q); end
    load(32'h1000_0000, 4'hF, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL count_wrap got=%h exp=0", q); end
    load(32'h1000_000C, 4'hF, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL rsvd_reg got=%h exp=0", q); end
    repeat (3) @(negedge clk);
    store(32'h1000_0008, 32'h7, 4'b0001, q);
    load(32'h1000_0008, 4'hF, q);
    checks++; if (q !== 32'h7) begin errors++; $display("FAIL match_beats_w1c got=%h exp=7", q); end
    @(negedge clk);
    checks++; if (timer_int_o !== 1'b1) begin errors++; $display("FAIL int_reassert got=%b exp=1", timer_int_o); end
  endtask
`else
  task automatic test_no_timer;
    logic [31:0] q;
    store(32'h1000_0010, 32'hCAFEF00D, 4'hF, q);
    load(32'h1000_0010, 4'hF, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL timer_region_load got=%h exp=0", q); end
    load(32'h1000_0000, 4'hF, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL timer_count_load got=%h exp=0", q); end
    load(32'h10, 4'hF, q);
    checks++; if (q !== 32'hA5A5A5A5) begin errors++; $display("FAIL timer_region_store got=%h exp=a5a5a5a5", q); end
    checks++; if (timer_int_o !== 1'b0) begin errors++; $display("FAIL int_tied got=%b exp=0", timer_int_o); end
  endtask
`endif
  task automatic test_rst_mid;
    logic [31:0] q;
    rst = 1'b1; bus.ce = 1'b1; bus.we = 1'b1; bus.addr = 32'h10; bus.data_i = 32'h11111111; bus.sel = 4'hF;
    @(negedge clk);
    bus.we = 1'b0;
    #1;
    checks++; if (bus.data_o !== 32'h0) begin errors++; $display("FAIL rst_load got=%h exp=0", bus.data_o); end
    @(negedge clk);
    rst = 1'b0; bus.ce = 1'b0;
    load(32'h10, 4'hF, q);
    checks++; if (q !== 32'hA5A5A5A5) begin errors++; $display("FAIL rst_store_dropped got=%h exp=a5a5a5a5", q); end
    checks++; if (timer_int_o !== 1'b0) begin errors++; $display("FAIL rst_int got=%b exp=0", timer_int_o); end
`ifdef DATA_RAM_TIMER_EN
    load(32'h1000_0000, 4'hF, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL rst_count got=%h exp=0", q); end
    load(32'h1000_0004, 4'hF, q);
    checks++; if (q !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_compare got=%h exp=ffffffff", q); end
    load(32'h1000_0008, 4'hF, q);
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL rst_ctrl got=%h exp=0", q); end
`endif
  endtask
  initial begin
    rst = 1'b1; bus.ce = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.sel = '0; bus.data_i = '0;
    @(negedge clk);
    test_reset;
    test_ram_lanes;
    test_alias_unmapped;
`ifdef DATA_RAM_TIMER_EN
    test_timer;
`else
    test_no_timer;
`endif
    test_rst_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
